// File: rtl/postage_maxi_deadlock_watchdog.sv
// Qualifies sustained blocking from the postage_maxi deadlock monitor as a deadlock.
// On detection it latches a sticky diagnostic record and pulses an interrupt for one cycle.
module postage_maxi_deadlock_watchdog #(
  parameter int NUM_AXIS  = 2,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1024,
  parameter int TS_W      = 32,
  parameter int EVT_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                enable,
  input  logic                clear,
  output logic                deadlock,
  output logic                deadlock_irq,
  output logic [NUM_AXIS-1:0] culprit,
  output logic [TS_W-1:0]     deadlock_time,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    max_stall,
  output logic [EVT_W-1:0]    event_count
);

  typedef enum logic [1:0] {IDLE, WATCH, DEADLOCK} state_t;

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(THRESHOLD);

  state_t           state;
  logic [TS_W-1:0]  timestamp;
  logic [CNT_W-1:0] stall_inc;
  logic [CNT_W-1:0] stall_sat;
  logic [EVT_W-1:0] event_sat;
  logic             stalling;
  logic             detect;

  // NOTE: combinational helpers use blocking assignments with a default for
  // every output first, so no latch can be inferred.
  always_comb begin
    stalling  = block && enable;
    stall_inc = stall_cycles + CNT_W'(1);
    stall_sat = (stall_cycles == '1) ? stall_cycles : stall_inc;
    event_sat = (event_count == '1) ? event_count : event_count + EVT_W'(1);
    detect    = 1'b0;
    if (!clear) begin
      case (state)
        IDLE:    detect = stalling && (THRESHOLD == 1);
        WATCH:   detect = stalling && (stall_inc == THRESH);
        default: detect = 1'b0;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments; reset is synchronous to
  // match the surrounding codebase and returns every register to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      timestamp     <= '0;
      deadlock      <= 1'b0;
      deadlock_irq  <= 1'b0;
      culprit       <= '0;
      deadlock_time <= '0;
      stall_cycles  <= '0;
      max_stall     <= '0;
      event_count   <= '0;
    end else begin
      timestamp    <= timestamp + TS_W'(1);
      deadlock_irq <= 1'b0;
      if (stall_cycles > max_stall) max_stall <= stall_cycles;

      if (clear) begin
        state         <= IDLE;
        deadlock      <= 1'b0;
        culprit       <= '0;
        deadlock_time <= '0;
        stall_cycles  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (stalling) begin
              stall_cycles <= CNT_W'(1);
              state        <= (THRESHOLD == 1) ? DEADLOCK : WATCH;
            end else begin
              stall_cycles <= '0;
            end
          end
          WATCH: begin
            if (stalling) begin
              stall_cycles <= stall_inc;
              if (stall_inc == THRESH) state <= DEADLOCK;
            end else begin
              stall_cycles <= '0;
              state        <= IDLE;
            end
          end
          DEADLOCK: begin
            // enable is deliberately ignored here; only clear or reset leaves.
            stall_cycles <= block ? stall_sat : '0;
          end
          default: state <= IDLE;
        endcase
      end

      if (detect) begin
        deadlock      <= 1'b1;
        deadlock_irq  <= 1'b1;
        culprit       <= axis_block_sigs;
        deadlock_time <= timestamp;
        event_count   <= event_sat;
      end
    end
  end

endmodule

// File: tb/tb_postage_maxi_deadlock_watchdog.sv
// Directed self-checking bench: a THRESHOLD=4 instance for the main scenarios and
// a THRESHOLD=1 / EVT_W=2 instance for per-pulse detection and event saturation.
module tb_postage_maxi_deadlock_watchdog;

  logic       clock = 1'b0;
  logic       reset;
  logic       block;
  logic [1:0] axis_block_sigs;
  logic       enable;
  logic       clear;

  logic        deadlock, deadlock_irq;
  logic [1:0]  culprit;
  logic [31:0] deadlock_time;
  logic [15:0] stall_cycles, max_stall;
  logic [7:0]  event_count;

  logic        deadlock_b, deadlock_irq_b;
  logic [1:0]  culprit_b;
  logic [31:0] deadlock_time_b;
  logic [15:0] stall_cycles_b, max_stall_b;
  logic [1:0]  event_count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  postage_maxi_deadlock_watchdog #(.NUM_AXIS(2), .CNT_W(16), .THRESHOLD(4), .TS_W(32), .EVT_W(8)) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_sigs(axis_block_sigs),
    .enable(enable), .clear(clear), .deadlock(deadlock), .deadlock_irq(deadlock_irq),
    .culprit(culprit), .deadlock_time(deadlock_time), .stall_cycles(stall_cycles),
    .max_stall(max_stall), .event_count(event_count)
  );

  postage_maxi_deadlock_watchdog #(.NUM_AXIS(2), .CNT_W(16), .THRESHOLD(1), .TS_W(32), .EVT_W(2)) dut_b (
    .clock(clock), .reset(reset), .block(block), .axis_block_sigs(axis_block_sigs),
    .enable(enable), .clear(clear), .deadlock(deadlock_b), .deadlock_irq(deadlock_irq_b),
    .culprit(culprit_b), .deadlock_time(deadlock_time_b), .stall_cycles(stall_cycles_b),
    .max_stall(max_stall_b), .event_count(event_count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed the inputs.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int irq_seen;
    int dl_seen;
    int stall_seen;

    block = 1'b0; axis_block_sigs = 2'b00; enable = 1'b0; clear = 1'b0;
    do_reset();

    check("rst_deadlock", deadlock, 0);
    check("rst_irq", deadlock_irq, 0);
    check("rst_culprit", culprit, 0);
    check("rst_time", deadlock_time, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_max", max_stall, 0);
    check("rst_events", event_count, 0);

    // Basic detection: 4th sampled block edge sees timestamp 3.
    enable = 1'b1; block = 1'b1; axis_block_sigs = 2'b10;
    tick(3);
    check("t1_stall3", stall_cycles, 3);
    check("t1_no_dl_yet", deadlock, 0);
    tick();
    check("t1_deadlock", deadlock, 1);
    check("t1_irq", deadlock_irq, 1);
    check("t1_culprit", culprit, 2'b10);
    check("t1_events", event_count, 1);
    check("t1_time", deadlock_time, 3);
    check("t1_stall4", stall_cycles, 4);

    // Held in DEADLOCK: no second irq, stall keeps counting, inputs ignored for culprit.
    axis_block_sigs = 2'b01;
    irq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (deadlock_irq) irq_seen++;
    end
    check("t3_no_irq", irq_seen, 0);
    check("t3_events", event_count, 1);
    check("t3_stall14", stall_cycles, 14);
    check("t3_max_lag", max_stall, 13);
    check("t3_culprit_held", culprit, 2'b10);

    clear = 1'b1;
    tick();
    check("t3_clr_deadlock", deadlock, 0);
    check("t3_clr_culprit", culprit, 0);
    check("t3_clr_stall", stall_cycles, 0);
    check("t3_clr_time", deadlock_time, 0);
    check("t3_clr_events", event_count, 1);
    check("t3_clr_max", max_stall, 14);

    // Re-detection with block still high; timestamps sampled 15..18.
    clear = 1'b0;
    tick(3);
    check("t3_redet_early", deadlock, 0);
    tick();
    check("t3_redet", deadlock, 1);
    check("t3_redet_irq", deadlock_irq, 1);
    check("t3_redet_events", event_count, 2);
    check("t3_redet_time", deadlock_time, 18);
    check("t3_redet_culprit", culprit, 2'b01);

    // Two sub-threshold bursts.
    block = 1'b0; clear = 1'b0;
    do_reset();
    block = 1'b1; axis_block_sigs = 2'b11;
    tick(3);
    check("t2_stall3", stall_cycles, 3);
    block = 1'b0;
    tick();
    check("t2_gap_stall", stall_cycles, 0);
    check("t2_gap_max", max_stall, 3);
    block = 1'b1;
    tick(3);
    check("t2_stall3b", stall_cycles, 3);
    block = 1'b0;
    tick(2);
    check("t2_no_deadlock", deadlock, 0);
    check("t2_max", max_stall, 3);
    check("t2_events", event_count, 0);

    // clear coincides with the would-be detection edge.
    block = 1'b1;
    tick(3);
    clear = 1'b1;
    tick();
    check("t4_deadlock", deadlock, 0);
    check("t4_irq", deadlock_irq, 0);
    check("t4_events", event_count, 0);
    check("t4_stall", stall_cycles, 0);
    clear = 1'b0; block = 1'b0;
    tick();

    // enable low: no counting, no detection.
    enable = 1'b0; block = 1'b1;
    dl_seen = 0; stall_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (deadlock) dl_seen++;
      if (stall_cycles != 0) stall_seen++;
    end
    check("t6_en0_deadlock", dl_seen, 0);
    check("t6_en0_stall", stall_seen, 0);

    enable = 1'b1;
    tick(4);
    check("t6_deadlock", deadlock, 1);
    enable = 1'b0;
    tick();
    check("t6_en_ignored", deadlock, 1);
    check("t6_en_ignored_stall", stall_cycles, 5);

    // Reset while in DEADLOCK.
    reset = 1'b1;
    tick();
    check("t6_rst_deadlock", deadlock, 0);
    check("t6_rst_irq", deadlock_irq, 0);
    check("t6_rst_culprit", culprit, 0);
    check("t6_rst_time", deadlock_time, 0);
    check("t6_rst_stall", stall_cycles, 0);
    check("t6_rst_max", max_stall, 0);
    check("t6_rst_events", event_count, 0);
    reset = 1'b0;

    // THRESHOLD=1 instance: irq on every isolated pulse, event_count saturates at 3.
    block = 1'b0; enable = 1'b1; clear = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      block = 1'b1; clear = 1'b0; axis_block_sigs = 2'b01;
      tick();
      check($sformatf("t5_irq%0d", i), deadlock_irq_b, 1);
      check($sformatf("t5_dl%0d", i), deadlock_b, 1);
      check($sformatf("t5_ev%0d", i), event_count_b, (i < 3) ? i + 1 : 3);
      block = 1'b0; clear = 1'b1;
      tick();
      check($sformatf("t5_clr%0d", i), deadlock_b, 0);
    end
    check("t5_culprit_cleared", culprit_b, 0);
    check("t5_max", max_stall_b, 1);
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/postage_maxi_deadlock_watchdog.md
Name: postage_maxi_deadlock_watchdog

Overview:
Sits directly downstream of the postage_maxi HLS deadlock monitor.
It consumes the monitor's per-cycle `block` flag and the raw `axis_block_sigs`, and qualifies sustained blocking as a deadlock once a programmable number of consecutive cycles is reached.
On detection it latches a sticky diagnostic record (culprit stream mask, timestamp, stall statistics) and raises a one-cycle interrupt pulse toward the control/status register block.

Parameters:
NUM_AXIS, 2, width of axis_block_sigs / culprit mask
CNT_W, 16, width of stall counters
THRESHOLD, 1024, consecutive block cycles that qualify a deadlock; legal range 1..2^CNT_W-1
TS_W, 32, width of free-running timestamp
EVT_W, 8, width of saturating deadlock event counter

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
block  in  1  per-cycle block flag from deadlock monitor
axis_block_sigs  in  NUM_AXIS  per-stream block flags (same cycle alignment as block)
enable  in  1  detection enable
clear  in  1  acknowledge; clears sticky deadlock record
deadlock  out  1  sticky deadlock flag
deadlock_irq  out  1  one-cycle pulse on deadlock entry
culprit  out  NUM_AXIS  axis_block_sigs captured at detection
deadlock_time  out  TS_W  timestamp captured at detection
stall_cycles  out  CNT_W  current consecutive block-cycle count
max_stall  out  CNT_W  largest stall_cycles seen since reset
event_count  out  EVT_W  number of deadlocks detected, saturating

Behaviour:
- Reset: all outputs 0; timestamp 0; state IDLE.
- Timestamp: free-running, +1 every cycle, wraps modulo 2^TS_W.
- Register semantics: all outputs are registered. "At edge E" means the value is visible in the cycle after the edge at which the inputs were sampled.
- States: IDLE, WATCH, DEADLOCK.
- IDLE:
  - stall_cycles = 0.
  - enable & block -> stall_cycles <= 1. If THRESHOLD == 1, go directly to DEADLOCK (detection, below); otherwise go to WATCH.
- WATCH:
  - block & enable -> stall_cycles <= stall_cycles+1.
  - If stall_cycles+1 == THRESHOLD -> detection on this edge; go to DEADLOCK.
  - !block | !enable -> stall_cycles <= 0; go to IDLE.
- Detection edge (all of the following on the same edge):
  - deadlock <= 1; deadlock_irq <= 1 for exactly one cycle.
  - culprit <= axis_block_sigs sampled on that edge.
  - deadlock_time <= timestamp sampled on that edge.
  - event_count <= event_count+1, saturating at all-ones.
- DEADLOCK:
  - deadlock, culprit and deadlock_time are held; no re-detection and no further irq.
  - stall_cycles keeps incrementing while block is high, saturating at 2^CNT_W-1; it goes to 0 when block drops.
  - enable is ignored in this state.
- clear:
  - Any state -> IDLE; deadlock, culprit, deadlock_time, stall_cycles <= 0.
  - event_count and max_stall are unaffected.
  - clear has priority over a detection or increment on the same edge.
- max_stall: when stall_cycles > max_stall, max_stall <= stall_cycles (one-cycle lag; never decreases until reset).
- enable low outside DEADLOCK: stall_cycles forced to 0, no detection.
- Reset mid-stall or mid-deadlock: everything returns to reset values the next edge; no irq is generated.
- Latency: THRESHOLD consecutive sampled block=1 -> deadlock and deadlock_irq high in the following cycle.

Test Plan:
1. THRESHOLD=4, enable=1, block high 4 cycles with axis_block_sigs=2'b10 -> deadlock=1 and irq pulse 1 cycle after 4th sample; culprit=2'b10; event_count=1; deadlock_time equals timestamp at 4th sample.
2. THRESHOLD=4, block high 3 cycles, low 1, high 3 -> no deadlock; max_stall=3; stall_cycles returns to 0 between bursts.
3. In DEADLOCK, block held high 10 more cycles then clear=1 -> no second irq, event_count stays 1; after clear, deadlock=0, culprit=0, stall_cycles=0; block still high -> re-detection 4 cycles later with event_count=2.
4. clear asserted on the same edge as the would-be detection -> deadlock stays 0, irq not pulsed, event_count unchanged, stall_cycles=0.
5. THRESHOLD=1, EVT_W=2, 5 isolated block pulses each followed by clear -> irq on every pulse; event_count saturates at 3.
6. enable=0 with block high 20 cycles -> no deadlock, stall_cycles=0; reset asserted during DEADLOCK -> all outputs 0 the next cycle.
